flash_bus_arbiter: RTL and testbench

- Shares the single parallel flash bus between two masters: requester 0 (spi_flash_ctrl, SPI debug/programming path) and requester 1 (on-chip boot/config loader).
- Each requester uses the existing flash_access_req / flash_access_ack handshake.
- Block grants ownership round-robin, muxes the owner's address/data/strobes onto the flash pins, and inserts idle turnaround cycles between owners.
- Sits between the requesters and the top-level flash pin drivers; flashDataIn and flashBusy fan out to both requesters directly, not through this block.

---
 rtl/flash_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_flash_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_bus_arbiter.sv
// Two-master arbiter for the shared parallel flash bus: round-robin grant with a
// req/ack handshake, an owner pin mux, forced idle turnaround and a hold-time monitor.
module flash_bus_arbiter #(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    output logic [1:0]  ack,
    input  logic [21:0] addr0,
    input  logic [21:0] addr1,
    input  logic [15:0] dout0,
    input  logic [15:0] dout1,
    input  logic [1:0]  cs_n,
    input  logic [1:0]  oe_n,
    input  logic [1:0]  we_n,
    input  logic [1:0]  oen_en,
    output logic [21:0] flashAddr,
    output logic [15:0] flashDataOut,
    output logic        flashCS,
    output logic        flashOE,
    output logic        flashWE,
    output logic        flashEnableOutput,
    output logic        owner,
    output logic        hold_err,
    output logic [1:0]  fsm_state
);

    // Handshake: req[i] is raised to ask for the bus and held for the whole flash
    // operation; ack[i] rises one edge after the grant decision and falls one edge
    // after req[i] is sampled low. At most one ack bit is ever set.

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W:0] HOLD_LIMIT = (HOLD_W + 1)'(MAX_HOLD);
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    state_t            state, state_next;
    logic              last, last_next;
    logic              owner_next;
    logic [3:0]        turn_cnt, turn_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W:0]   hold_inc;
    logic              in_grant;
    logic              other_req;

    assign fsm_state = state;
    assign in_grant  = (state == ST_GRANT0) || (state == ST_GRANT1);
    assign other_req = (state == ST_GRANT0) ? req[1] : req[0];
    assign hold_inc  = {1'b0, hold_cnt} + 1'b1;

    always_comb begin
        state_next = state;
        last_next  = last;
        owner_next = owner;
        turn_next  = turn_cnt;
        case (state)
            ST_IDLE: begin
                if (req[0] && (!req[1] || last)) begin
                    state_next = ST_GRANT0;
                    owner_next = 1'b0;
                end else if (req[1]) begin
                    state_next = ST_GRANT1;
                    owner_next = 1'b1;
                end
            end
            ST_GRANT0: begin
                if (!req[0]) begin
                    state_next = ST_TURN;
                    last_next  = 1'b0;
                    turn_next  = TURN_LOAD;
                end
            end
            ST_GRANT1: begin
                if (!req[1]) begin
                    state_next = ST_TURN;
                    last_next  = 1'b1;
                    turn_next  = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (turn_cnt == 4'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    turn_next = turn_cnt - 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ack      <= 2'b00;
            last     <= 1'b1;
            owner    <= 1'b0;
            turn_cnt <= 4'd0;
            hold_cnt <= '0;
            hold_err <= 1'b0;
        end else begin
            state    <= state_next;
            ack      <= {state_next == ST_GRANT1, state_next == ST_GRANT0};
            last     <= last_next;
            owner    <= owner_next;
            turn_cnt <= turn_next;
            // Counts only the cycles the other side spends waiting on this grant.
            if (state == ST_IDLE) begin
                hold_cnt <= '0;
            end else if (in_grant && other_req) begin
                if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                if ((MAX_HOLD != 0) && (hold_inc >= HOLD_LIMIT)) begin
                    hold_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        flashAddr         = 22'd0;
        flashDataOut      = 16'd0;
        flashCS           = 1'b1;
        flashOE           = 1'b1;
        flashWE           = 1'b1;
        flashEnableOutput = 1'b0;
        case (state)
            ST_GRANT0: begin
                flashAddr         = addr0;
                flashDataOut      = dout0;
                flashCS           = cs_n[0];
                flashOE           = oe_n[0];
                flashWE           = we_n[0];
                flashEnableOutput = oen_en[0];
            end
            ST_GRANT1: begin
                flashAddr         = addr1;
                flashDataOut      = dout1;
                flashCS           = cs_n[1];
                flashOE           = oe_n[1];
                flashWE           = we_n[1];
                flashEnableOutput = oen_en[1];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Bench for flash_bus_arbiter: directed scenarios plus a random phase, every cycle
// compared against a bus-ownership model built from the arbitration rules.
module tb_flash_bus_arbiter;

    localparam int TURN = 2;
    localparam int MAXH = 16;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [21:0] addr0, addr1;
    logic [15:0] dout0, dout1;
    logic [1:0]  cs_n, oe_n, we_n, oen_en;
    logic [21:0] flashAddr;
    logic [15:0] flashDataOut;
    logic        flashCS, flashOE, flashWE, flashEnableOutput;
    logic        owner, hold_err;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the bus (-1 = nobody), enforced idle edges left before
    // arbitration may run, last releaser, waiting-cycle count and sticky error.
    int   m_owner;
    int   m_gap;
    int   m_last;
    int   m_hold;
    logic m_err;
    logic m_owner_out;

    flash_bus_arbiter #(.TURN_CYCLES(TURN), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .ack(ack),
        .addr0(addr0), .addr1(addr1), .dout0(dout0), .dout1(dout1),
        .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n), .oen_en(oen_en),
        .flashAddr(flashAddr), .flashDataOut(flashDataOut),
        .flashCS(flashCS), .flashOE(flashOE), .flashWE(flashWE),
        .flashEnableOutput(flashEnableOutput), .owner(owner),
        .hold_err(hold_err), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner     = -1;
        m_gap       = 0;
        m_last      = 1;
        m_hold      = 0;
        m_err       = 1'b0;
        m_owner_out = 1'b0;
    endtask

    task automatic model_edge();
        int g;
        g = -1;
        if (m_owner >= 0) begin
            if (req[1 - m_owner]) m_hold++;
            if (MAXH != 0 && m_hold >= MAXH) m_err = 1'b1;
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = TURN;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            if (req == 2'b01) g = 0;
            else if (req == 2'b10) g = 1;
            else if (req == 2'b11) g = 1 - m_last;
            if (g >= 0) begin
                m_owner     = g;
                m_owner_out = g[0];
                m_hold      = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0]  e_ack;
        logic [21:0] e_addr;
        logic [15:0] e_data;
        logic        e_cs, e_oe, e_we, e_en;
        e_ack = 2'b00; e_addr = 22'd0; e_data = 16'd0;
        e_cs = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_en = 1'b0;
        if (m_owner == 0) begin
            e_ack = 2'b01; e_addr = addr0; e_data = dout0;
            e_cs = cs_n[0]; e_oe = oe_n[0]; e_we = we_n[0]; e_en = oen_en[0];
        end else if (m_owner == 1) begin
            e_ack = 2'b10; e_addr = addr1; e_data = dout1;
            e_cs = cs_n[1]; e_oe = oe_n[1]; e_we = we_n[1]; e_en = oen_en[1];
        end
        chk("ack", ack, e_ack);
        chk("owner", owner, m_owner_out);
        chk("hold_err", hold_err, m_err);
        chk("flashAddr", flashAddr, e_addr);
        chk("flashDataOut", flashDataOut, e_data);
        chk("flashCS", flashCS, e_cs);
        chk("flashOE", flashOE, e_oe);
        chk("flashWE", flashWE, e_we);
        chk("flashEnableOutput", flashEnableOutput, e_en);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Called 1 time unit after a rising edge; reset lands mid-cycle.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic rand_side();
        addr0  = 22'($urandom);
        addr1  = 22'($urandom);
        dout0  = 16'($urandom);
        dout1  = 16'($urandom);
        cs_n   = 2'($urandom);
        oe_n   = 2'($urandom);
        we_n   = 2'($urandom);
        oen_en = 2'($urandom);
    endtask

    initial begin
        int grants;
        int idle_run;
        int held;
        logic [1:0] prev_ack;

        reset_n = 1'b1;
        req = 2'b00;
        addr0 = 22'd0; addr1 = 22'd0; dout0 = 16'h1111; dout1 = 16'd0;
        cs_n = 2'b11; oe_n = 2'b11; we_n = 2'b11; oen_en = 2'b00;
        model_reset();
        async_reset();

        // Single request, then isolation from requester 1 during the grant.
        repeat (4) step();
        req = 2'b01; addr0 = 22'h123456; cs_n = 2'b10;
        step();
        chk("t1_ack", ack, 2'b01);
        chk("t1_addr", flashAddr, 22'h123456);
        chk("t1_cs", flashCS, 1'b0);
        for (int k = 0; k < 14; k++) begin
            addr1 = ~addr1; dout1 = ~dout1; cs_n[1] = ~cs_n[1]; we_n[1] = ~we_n[1];
            step();
            chk("iso_addr", flashAddr, 22'h123456);
            chk("iso_data", flashDataOut, 16'h1111);
            chk("iso_cs", flashCS, 1'b0);
        end
        req = 2'b00;
        step();
        chk("t1_rel_ack", ack, 2'b00);
        chk("t1_rel_cs", flashCS, 1'b1);
        step();
        chk("t1_turn_cs", flashCS, 1'b1);
        repeat (3) step();

        // Tie after reset: requester 0 first, then requester 1 after turnaround.
        async_reset();
        req = 2'b11; dout1 = 16'hBEEF;
        step();
        chk("t2_first", ack, 2'b01);
        repeat (3) step();
        req = 2'b10;
        step();
        chk("t2_rel", ack, 2'b00);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t2_gap", ack, 2'b00);
        end
        step();
        chk("t2_second", ack, 2'b10);
        chk("t2_owner", owner, 1'b1);
        chk("t2_data", flashDataOut, 16'hBEEF);
        req = 2'b00;
        repeat (4) step();

        // Round-robin: both always requesting, each releases after 8 grant cycles.
        grants = 0; idle_run = 0; held = 0; prev_ack = ack;
        for (int k = 0; k < 200 && grants < 4; k++) begin
            req = 2'b11;
            if (m_owner >= 0 && held >= 8) req[m_owner] = 1'b0;
            rand_side();
            step();
            if (m_owner >= 0) held++; else held = 0;
            if (ack != 2'b00 && prev_ack == 2'b00) begin
                grants++;
                chk("rr_order", ack, (grants % 2 == 1) ? 2'b01 : 2'b10);
                if (grants > 1) chk("rr_gap", idle_run, TURN + 1);
            end
            if (ack == 2'b00) idle_run++; else idle_run = 0;
            prev_ack = ack;
        end
        chk("rr_count", grants, 4);
        req = 2'b00;
        repeat (5) step();

        // No preemption and hold-time flag with the other side waiting.
        async_reset();
        req = 2'b11;
        step();
        chk("hold_grant", ack, 2'b01);
        repeat (15) step();
        chk("hold_err_15", hold_err, 1'b0);
        step();
        chk("hold_err_16", hold_err, 1'b1);
        for (int k = 0; k < 23; k++) begin
            step();
            chk("no_preempt", ack, 2'b01);
        end
        req = 2'b10;
        repeat (3) step();
        chk("hold_wait", ack, 2'b00);
        step();
        chk("hold_next", ack, 2'b10);

        // Reset in the middle of a requester-1 write.
        we_n = 2'b01;
        step();
        chk("wr_we", flashWE, 1'b0);
        async_reset();
        chk("rst_we", flashWE, 1'b1);
        chk("rst_ack", ack, 2'b00);
        chk("rst_err", hold_err, 1'b0);
        step();
        chk("rst_regrant", ack, 2'b10);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 3) == 0) req[1] = ~req[1];
            rand_side();
            step();
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
